// File: rtl/muldiv_if.sv
// Handshake/result bundle for the sequential multiply/divide unit.
// The master side issues operations and MTHI/MTLO writes; the slave side is the unit.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, dbz, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, dbz, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO registers (IDLE -> RUN x32 -> FIX).
// Define MULDIV_FAST_MULT_EN to compute multiplies in one cycle and skip RUN.
module muldiv_seq (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mb_q, mb_d, hi_q, hi_d, lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d, rsgn_q, rsgn_d, div_q, div_d, dbzp_q, dbzp_d;
  logic        done_q, dbz_q;

  logic        accept, running, fix_wr, mt_ok;
  logic        sgn_op, is_div, b_zero, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign sgn_op = ~bus.op[0];
  assign is_div = bus.op[1];
  assign b_zero = (bus.b == 32'd0);
  assign a_neg  = sgn_op & bus.a[31];
  assign b_neg  = sgn_op & bus.b[31];
  assign a_mag  = a_neg ? (32'd0 - bus.a) : bus.a;
  assign b_mag  = b_neg ? (32'd0 - bus.b) : bus.b;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [32:0] mul_sum, rem_sh;
  logic [63:0] mul_nxt, div_nxt;
  logic [31:0] rem_sub;
  logic        ge;

  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mb_q} : 33'd0);
  assign mul_nxt = {mul_sum, acc_q[31:1]};
  assign rem_sh  = acc_q[63:31];
  assign ge      = (rem_sh >= {1'b0, mb_q});
  assign rem_sub = rem_sh[31:0] - mb_q;
  assign div_nxt = {(ge ? rem_sub : rem_sh[31:0]), acc_q[30:0], ge};

  logic [63:0] prod;
  logic [31:0] quo, rem, res_hi, res_lo;

  assign prod = neg_q  ? (64'd0 - acc_q)        : acc_q;
  assign quo  = neg_q  ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
  assign rem  = rsgn_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (dbzp_q) begin
      res_hi = acc_q[31:0];
      res_lo = 32'hFFFF_FFFF;
    end else if (div_q) begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        if (is_div && b_zero) state_d = S_FIX;
`ifdef MULDIV_FAST_MULT_EN
        else if (!is_div)     state_d = S_FIX;
`endif
        else                  state_d = S_RUN;
      end
      S_RUN:   if (cnt_q == 5'd31) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    accept  = (state_q == S_IDLE) &  bus.start;
    mt_ok   = (state_q == S_IDLE) & ~bus.start;
    running = (state_q == S_RUN);
    fix_wr  = (state_q == S_FIX);
  end

  always_comb begin
    acc_d  = acc_q;
    mb_d   = mb_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    rsgn_d = rsgn_q;
    div_d  = div_q;
    dbzp_d = dbzp_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (accept) begin
      mb_d   = b_mag;
      cnt_d  = 5'd0;
      div_d  = is_div;
      neg_d  = a_neg ^ b_neg;
      rsgn_d = a_neg;
      dbzp_d = is_div & b_zero;
      // divide-by-zero keeps the raw dividend so FIX can return it in HI
      acc_d  = (is_div & b_zero) ? {32'd0, bus.a} : {32'd0, a_mag};
`ifdef MULDIV_FAST_MULT_EN
      if (!is_div) acc_d = {32'd0, a_mag} * {32'd0, b_mag};
`endif
    end else if (running) begin
      cnt_d = cnt_q + 5'd1;
      acc_d = div_q ? div_nxt : mul_nxt;
    end else if (fix_wr) begin
      hi_d   = res_hi;
      lo_d   = res_lo;
      dbzp_d = 1'b0;
    end else if (mt_ok) begin
      if (bus.hi_we) hi_d = bus.wdata;
      if (bus.lo_we) lo_d = bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      mb_q   <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      rsgn_q <= 1'b0;
      div_q  <= 1'b0;
      dbzp_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      mb_q   <= mb_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      rsgn_q <= rsgn_d;
      div_q  <= div_d;
      dbzp_q <= dbzp_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= fix_wr;
      dbz_q  <= fix_wr & dbzp_q;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
